// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter that shares one UART TX byte stream between
// two requesters, with an inter-message idle gap and a stall watchdog on the owner.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic       abort,
  output logic       abort_src,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [TW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam state_t AFTER_MSG = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t        state;
  logic          owner;
  logic          last_served;
  logic          abort_src_q;
  logic [1:0]    grant_q;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] wd_cnt;

  logic       in_grant;
  logic       owner_valid;
  logic       owner_last;
  logic [7:0] owner_data;
  logic       xfer_last;
  logic       timeout;
  logic       pick;

  // Handshake: a byte moves on any cycle with m_valid && m_ready; in GRANT the
  // owner's valid/data/last pass straight through and its ready mirrors m_ready,
  // while the non-owner sees ready=0 and its valid is ignored.
  always_comb begin
    in_grant    = (state == GRANT);
    owner_valid = owner ? s1_valid : s0_valid;
    owner_last  = owner ? s1_last : s0_last;
    owner_data  = owner ? s1_data : s0_data;

    m_valid  = in_grant & owner_valid;
    m_last   = in_grant & owner_valid & owner_last;
    m_data   = in_grant ? owner_data : 8'h00;
    s0_ready = in_grant & ~owner & m_ready;
    s1_ready = in_grant & owner & m_ready;

    xfer_last = m_valid & m_ready & m_last;
    // The T-th consecutive starved cycle aborts in the same cycle; a valid owner wins.
    timeout   = in_grant & ~owner_valid & (wd_cnt == WD_LAST) & ~reset;

    // Tie goes to the requester not served last; a lone requester always wins.
    pick = (s0_valid & s1_valid) ? ~last_served : s1_valid;

    abort     = timeout;
    abort_src = timeout ? owner : abort_src_q;
    grant     = grant_q;
    busy      = (state != IDLE);
    fsm_state = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      abort_src_q <= 1'b0;
      grant_q     <= 2'b00;
      gap_cnt     <= '0;
      wd_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s0_valid | s1_valid) begin
            owner   <= pick;
            grant_q <= pick ? 2'b10 : 2'b01;
            wd_cnt  <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (xfer_last || timeout) begin
            last_served <= owner;
            grant_q     <= 2'b00;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            state       <= AFTER_MSG;
            if (timeout) abort_src_q <= owner;
          end else if (owner_valid) begin
            wd_cnt <= '0;
          end else if (wd_cnt != WD_LAST) begin
            wd_cnt <= wd_cnt + TW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a gapped instance (G=4, T=10) checked by a byte scoreboard
// plus directed timing checks, and a gapless instance (G=0) checked for alternation.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Gapped instance
  logic [7:0] a_s0_data, a_s1_data, a_m_data;
  logic       a_s0_valid, a_s1_valid, a_s0_last, a_s1_last, a_s0_ready, a_s1_ready;
  logic       a_m_valid, a_m_last, a_m_ready, a_busy, a_abort, a_abort_src;
  logic [1:0] a_grant, a_fsm;

  // Gapless instance
  logic [7:0] b_s0_data, b_s1_data, b_m_data;
  logic       b_s0_valid, b_s1_valid, b_s0_last, b_s1_last, b_s0_ready, b_s1_ready;
  logic       b_m_valid, b_m_last, b_m_ready, b_busy, b_abort, b_abort_src;
  logic [1:0] b_grant, b_fsm;

  uart_tx_arbiter #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(10)) u_a (
    .clk(clk), .reset(reset),
    .s0_data(a_s0_data), .s0_valid(a_s0_valid), .s0_last(a_s0_last), .s0_ready(a_s0_ready),
    .s1_data(a_s1_data), .s1_valid(a_s1_valid), .s1_last(a_s1_last), .s1_ready(a_s1_ready),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_last(a_m_last), .m_ready(a_m_ready),
    .grant(a_grant), .busy(a_busy), .abort(a_abort), .abort_src(a_abort_src),
    .fsm_state(a_fsm)
  );

  uart_tx_arbiter #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(10)) u_b (
    .clk(clk), .reset(reset),
    .s0_data(b_s0_data), .s0_valid(b_s0_valid), .s0_last(b_s0_last), .s0_ready(b_s0_ready),
    .s1_data(b_s1_data), .s1_valid(b_s1_valid), .s1_last(b_s1_last), .s1_ready(b_s1_ready),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_last(b_m_last), .m_ready(b_m_ready),
    .grant(b_grant), .busy(b_busy), .abort(b_abort), .abort_src(b_abort_src),
    .fsm_state(b_fsm)
  );

  localparam int NM = 6;

  int checks = 0;
  int failures = 0;
  int abort_seen = 0;
  logic [9:0] exp_q[$];          // {src, last, data} in predicted service order
  logic [8:0] src0_q[$], src1_q[$];
  int len0[NM], len1[NM];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (a_m_valid && a_m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_xfer actual=%0h expected=none", a_m_data);
      end else begin
        e = exp_q.pop_front();
        chk("a_xfer", {21'd0, a_grant, a_m_last, a_m_data},
            {21'd0, (e[9] ? 2'b10 : 2'b01), e[8:0]});
      end
    end
    if (a_abort) abort_seen++;
    if (a_grant == 2'b01 && a_s1_valid) chk("a_iso_s1_ready", a_s1_ready, 0);
    if (a_grant == 2'b10 && a_s0_valid) chk("a_iso_s0_ready", a_s0_ready, 0);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_req(input int p, input logic v, input logic [7:0] d, input logic l);
    if (p == 0) begin
      a_s0_valid = v; a_s0_data = d; a_s0_last = l;
    end else begin
      a_s1_valid = v; a_s1_data = d; a_s1_last = l;
    end
  endtask

  // Present one byte and hold it until accepted; returns just after the accepting edge.
  task automatic send_byte(input int p, input logic [7:0] d, input logic l);
    int budget;
    logic rdy;
    budget = 0;
    set_req(p, 1'b1, d, l);
    forever begin
      @(negedge clk);
      rdy = (p == 0) ? a_s0_ready : a_s1_ready;
      if (rdy) break;
      budget++;
      if (budget > 3000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout port=%0d actual=no_ready expected=ready", p);
        break;
      end
    end
    @(posedge clk); #1;
    set_req(p, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic run_req(input int p);
    logic [8:0] e;
    forever begin
      if (p == 0) begin
        if (src0_q.size() == 0) break;
        e = src0_q.pop_front();
      end else begin
        if (src1_q.size() == 0) break;
        e = src1_q.pop_front();
      end
      send_byte(p, e[7:0], e[8]);
      if (!e[8]) idle($urandom_range(0, 3));
    end
  endtask

  // ---------------- main sequence ----------------
  logic [1:0] g_tab[13] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
                            2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
  logic       bz_tab[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    bit done;
    int n0, n1;
    logic hs0, hs1;
    logic [1:0] exp_g;
    reset = 1'b1;
    a_s0_data = 0; a_s1_data = 0; a_s0_valid = 0; a_s1_valid = 0;
    a_s0_last = 0; a_s1_last = 0; a_m_ready = 1'b1;
    b_s0_data = 0; b_s1_data = 0; b_s0_valid = 0; b_s1_valid = 0;
    b_s0_last = 0; b_s1_last = 0; b_m_ready = 1'b1;

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_grant", a_grant, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_abort", a_abort, 0);
    chk("rst_abort_src", a_abort_src, 0);
    chk("rst_m_valid", a_m_valid, 0);
    chk("rst_m_last", a_m_last, 0);
    chk("rst_m_data", a_m_data, 0);
    chk("rst_s0_ready", a_s0_ready, 0);
    chk("rst_s1_ready", a_s1_ready, 0);
    chk("rst_b_grant", b_grant, 0);

    // Gapless alternation: both send 1-byte messages continuously
    do_reset();
    b_s0_valid = 1; b_s1_valid = 1; b_s0_last = 1; b_s1_last = 1;
    b_s0_data = 8'h10; b_s1_data = 8'h80;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      hs0 = b_s0_valid & b_s0_ready;
      hs1 = b_s1_valid & b_s1_ready;
      exp_g = (k % 4 == 1) ? 2'b01 : ((k % 4 == 3) ? 2'b10 : 2'b00);
      chk("b_grant", b_grant, exp_g);
      if (k % 4 == 1) begin
        chk("b_valid0", b_m_valid, 1);
        chk("b_data0", b_m_data, 32'(8'h10 + k / 4));
      end else if (k % 4 == 3) begin
        chk("b_valid1", b_m_valid, 1);
        chk("b_data1", b_m_data, 32'(8'h80 + k / 4));
      end else begin
        chk("b_idle_valid", b_m_valid, 0);
      end
      @(posedge clk); #1;
      if (hs0) begin n0++; b_s0_data = 8'(8'h10 + n0); end
      if (hs1) begin n1++; b_s1_data = 8'(8'h80 + n1); end
    end
    b_s0_valid = 0; b_s1_valid = 0;
    chk("b_served0", n0, 10);
    chk("b_served1", n1, 10);

    // Both valid after reset, 3-byte messages, gap of 4
    do_reset();
    exp_q.push_back({2'b00, 8'h41}); exp_q.push_back({2'b00, 8'h42});
    exp_q.push_back({2'b01, 8'h43});
    exp_q.push_back({2'b10, 8'h61}); exp_q.push_back({2'b10, 8'h62});
    exp_q.push_back({2'b11, 8'h63});
    fork
      begin send_byte(0, 8'h41, 0); send_byte(0, 8'h42, 0); send_byte(0, 8'h43, 1); end
      begin send_byte(1, 8'h61, 0); send_byte(1, 8'h62, 0); send_byte(1, 8'h63, 1); end
      begin
        for (int k = 0; k < 13; k++) begin
          @(negedge clk);
          chk("s1_grant", a_grant, g_tab[k]);
          chk("s1_busy", a_busy, bz_tab[k]);
        end
      end
    join
    idle(6);

    // Non-owner isolation: requester 1 waits with 0xFF while requester 0 owns
    exp_q.push_back({2'b00, 8'h11}); exp_q.push_back({2'b00, 8'h12});
    exp_q.push_back({2'b01, 8'h13}); exp_q.push_back({2'b11, 8'hFF});
    fork
      begin send_byte(0, 8'h11, 0); send_byte(0, 8'h12, 0); send_byte(0, 8'h13, 1); end
      begin idle(1); send_byte(1, 8'hFF, 1); end
    join
    idle(6);

    // Backpressure far longer than the timeout never aborts
    a_m_ready = 1'b0;
    exp_q.push_back({2'b01, 8'h55});
    fork
      send_byte(0, 8'h55, 1);
      begin
        idle(50);
        @(negedge clk);
        chk("bp_grant", a_grant, 2'b01);
        chk("bp_valid", a_m_valid, 1);
        chk("bp_data", a_m_data, 8'h55);
        chk("bp_no_abort", abort_seen, 0);
        @(posedge clk); #1;
        a_m_ready = 1'b1;
      end
    join
    idle(6);

    // Owner starved for T-1 cycles then returns: valid wins, no abort
    exp_q.push_back({2'b00, 8'h21}); exp_q.push_back({2'b01, 8'h22});
    send_byte(0, 8'h21, 0);
    idle(9);
    send_byte(0, 8'h22, 1);
    chk("vw_no_abort", abort_seen, 0);
    idle(6);

    // Watchdog: requester 1 stalls mid-message
    exp_q.push_back({2'b10, 8'h31}); exp_q.push_back({2'b10, 8'h32});
    send_byte(1, 8'h31, 0);
    send_byte(1, 8'h32, 0);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk("wd_abort", a_abort, (k == 9) ? 1 : 0);
      if (k == 9) begin
        chk("wd_abort_src", a_abort_src, 1);
        chk("wd_grant_held", a_grant, 2'b10);
      end
      if (k == 10) chk("wd_grant_cleared", a_grant, 2'b00);
    end
    idle(6);
    chk("wd_src_held", a_abort_src, 1);

    // Reset after 2 of 5 bytes
    exp_q.push_back({2'b00, 8'h71}); exp_q.push_back({2'b00, 8'h72});
    send_byte(0, 8'h71, 0);
    send_byte(0, 8'h72, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mr_grant", a_grant, 0);
    chk("mr_busy", a_busy, 0);
    chk("mr_abort", a_abort, 0);
    chk("mr_abort_src", a_abort_src, 0);
    chk("mr_m_valid", a_m_valid, 0);
    chk("mr_m_data", a_m_data, 0);
    chk("mr_s0_ready", a_s0_ready, 0);
    @(posedge clk); #1;

    // Random messages from both, random backpressure; requester 0 wins the first tie
    for (int p = 0; p < 2; p++) begin
      for (int m = 0; m < NM; m++) begin
        int len;
        len = $urandom_range(1, 4);
        if (p == 0) len0[m] = len; else len1[m] = len;
        for (int k = 0; k < len; k++) begin
          logic [8:0] e;
          e = {(k == len - 1), 8'($urandom_range(0, 255))};
          if (p == 0) src0_q.push_back(e); else src1_q.push_back(e);
        end
      end
    end
    begin
      int m0, m1, i0, i1, pick;
      bit turn;
      m0 = 0; m1 = 0; i0 = 0; i1 = 0; turn = 0;
      while (m0 < NM || m1 < NM) begin
        if (turn == 0) pick = (m0 < NM) ? 0 : 1;
        else pick = (m1 < NM) ? 1 : 0;
        if (pick == 0) begin
          for (int k = 0; k < len0[m0]; k++) exp_q.push_back({1'b0, src0_q[i0 + k]});
          i0 += len0[m0]; m0++;
        end else begin
          for (int k = 0; k < len1[m1]; k++) exp_q.push_back({1'b1, src1_q[i1 + k]});
          i1 += len1[m1]; m1++;
        end
        turn = (pick == 0);
      end
    end
    done = 0;
    fork
      begin
        fork run_req(0); run_req(1); join
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          a_m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    a_m_ready = 1'b1;
    idle(8);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("abort_count", abort_seen, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
